uart_byte_tx: RTL and testbench

- Serial transmitter sitting directly downstream of the host output handler.
- Consumes its byte/rts strobe and serialises each byte onto the UART tx line as 8N1 (or 8N2), LSB first.
- A one-entry holding register decouples the handler from the bit shifter, so back-to-back frames go out with no idle gap.
- Reports ready/busy/done so the handler can pace its status and payload bytes.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_byte_tx_if.sv | 28 ++
 rtl/uart_baud_tick.sv | 32 +++
 rtl/uart_byte_tx.sv | 127 ++++++++++++
 tb/tb_uart_byte_tx.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: shifter states, frame geometry and default baud divisor.
// Shared by the byte transmitter and the planned receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  localparam int DATA_BITS            = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 868;

endpackage

// File: rtl/uart_byte_tx_if.sv
// Handshake between the host output handler (master) and the UART byte transmitter (slave).
// The byte is carried on 'data' because 'byte' is a reserved word in SystemVerilog.
interface uart_byte_tx_if;
  import uart_pkg::*;

  logic                 rts;
  logic [DATA_BITS-1:0] data;
  logic                 ready;
  logic                 busy;
  logic                 done;

  modport master (
    output rts,
    output data,
    input  ready,
    input  busy,
    input  done
  );

  modport slave (
    input  rts,
    input  data,
    output ready,
    output busy,
    output done
  );

endinterface

// File: rtl/uart_baud_tick.sv
// Free-running bit-period counter: tick on the last cycle of each bit,
// pre_tick one cycle earlier. The receiver will reuse it.
module uart_baud_tick import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick,
  output logic pre_tick
);

  localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
  localparam logic [W-1:0] PRE  = W'(CLKS_PER_BIT - 2);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + W'(1);
    end
  end

  assign tick     = (count == LAST);
  assign pre_tick = (count == PRE);

endmodule

// File: rtl/uart_byte_tx.sv
// 8N1/8N2 UART transmitter with a one-entry holding register in front of the shifter,
// so a byte queued during a frame starts right after the last stop bit.
module uart_byte_tx import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int STOP_BITS    = 1
) (
  input  logic           clk,
  input  logic           rst,
  uart_byte_tx_if.slave  host,
  output logic           tx
);

  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  state_t               state;
  logic [DATA_BITS-1:0] holding;
  logic                 holding_full;
  logic [DATA_BITS-1:0] shift;
  logic [IDX_W-1:0]     bit_idx;
  logic                 tick;
  logic                 pre_tick;
  logic                 baud_clear;
  logic                 stop_last;
  logic                 stop_end;
  logic                 load;
  logic                 accept;

  // The counter sits at zero while idle so each frame starts on a fresh bit period.
  assign baud_clear = (state == IDLE);

  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) baud (
    .clk      (clk),
    .rst      (rst),
    .clear    (baud_clear),
    .tick     (tick),
    .pre_tick (pre_tick)
  );

  assign stop_last = (bit_idx == STOP_LAST);
  assign stop_end  = (state == STOP) && stop_last && tick;
  assign load      = holding_full && ((state == IDLE) || stop_end);

  // A load frees the holding slot on the same edge, so a strobe then is still taken.
  assign accept     = host.rts && (!holding_full || load);
  assign host.ready = !holding_full;
  assign host.busy  = (state != IDLE) || holding_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      holding_full <= 1'b0;
      holding      <= '0;
    end else if (accept) begin
      holding_full <= 1'b1;
      holding      <= host.data;
    end else if (load) begin
      holding_full <= 1'b0;
    end
  end

  // done is raised one cycle ahead so it coincides with the final stop-bit cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shift     <= '0;
      bit_idx   <= '0;
      tx        <= 1'b1;
      host.done <= 1'b0;
    end else begin
      host.done <= (state == STOP) && stop_last && pre_tick;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (load) begin
            shift   <= holding;
            bit_idx <= '0;
            tx      <= 1'b0;
            state   <= START;
          end
        end
        START: begin
          if (tick) begin
            tx      <= shift[0];
            bit_idx <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_idx == DATA_LAST) begin
              tx      <= 1'b1;
              bit_idx <= '0;
              state   <= STOP;
            end else begin
              shift   <= shift >> 1;
              tx      <= shift[1];
              bit_idx <= bit_idx + IDX_W'(1);
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (stop_last) begin
              bit_idx <= '0;
              if (load) begin
                shift <= holding;
                tx    <= 1'b0;
                state <= START;
              end else begin
                tx    <= 1'b1;
                state <= IDLE;
              end
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
            end
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_byte_tx.sv
// Directed bench for uart_byte_tx: dut_a runs 4 clocks/bit with one stop bit,
// dut_b runs 3 clocks/bit with two stop bits.
module tb_uart_byte_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx_a;
  logic tx_b;
  int   checks = 0;
  int   errors = 0;

  uart_byte_tx_if if_a ();
  uart_byte_tx_if if_b ();

  uart_byte_tx #(.CLKS_PER_BIT(4), .STOP_BITS(1)) dut_a (
    .clk  (clk),
    .rst  (rst),
    .host (if_a),
    .tx   (tx_a)
  );

  uart_byte_tx #(.CLKS_PER_BIT(3), .STOP_BITS(2)) dut_b (
    .clk  (clk),
    .rst  (rst),
    .host (if_b),
    .tx   (tx_b)
  );

  always #5 clk = ~clk;

  // Expected line level k cycles after the accepting edge: start, 8 data bits LSB first, stop.
  function automatic logic exp_level(input logic [7:0] b, input int k, input int cpb);
    int idx;
    idx = (k - 1) / cpb;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    return 1'b1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [7:0] b);
    if_a.rts  = 1'b1;
    if_a.data = b;
    step();
    if_a.rts  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks += 8;
    if (tx_a !== 1'b1)       begin errors++; $display("[TB] FAIL reset_tx_a: got %b want 1", tx_a); end
    if (if_a.ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready_a: got %b want 1", if_a.ready); end
    if (if_a.busy !== 1'b0)  begin errors++; $display("[TB] FAIL reset_busy_a: got %b want 0", if_a.busy); end
    if (if_a.done !== 1'b0)  begin errors++; $display("[TB] FAIL reset_done_a: got %b want 0", if_a.done); end
    if (tx_b !== 1'b1)       begin errors++; $display("[TB] FAIL reset_tx_b: got %b want 1", tx_b); end
    if (if_b.ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready_b: got %b want 1", if_b.ready); end
    if (if_b.busy !== 1'b0)  begin errors++; $display("[TB] FAIL reset_busy_b: got %b want 0", if_b.busy); end
    if (if_b.done !== 1'b0)  begin errors++; $display("[TB] FAIL reset_done_b: got %b want 0", if_b.done); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_byte();
    send_a(8'hA5);
    checks += 3;
    if (if_a.ready !== 1'b0) begin errors++; $display("[TB] FAIL single_ready_accept: got %b want 0", if_a.ready); end
    if (if_a.busy !== 1'b1)  begin errors++; $display("[TB] FAIL single_busy_accept: got %b want 1", if_a.busy); end
    if (tx_a !== 1'b1)       begin errors++; $display("[TB] FAIL single_tx_accept: got %b want 1", tx_a); end
    for (int k = 1; k <= 41; k++) begin
      step();
      checks += 4;
      if (tx_a !== exp_level(8'hA5, k, 4))
        begin errors++; $display("[TB] FAIL single_tx k=%0d: got %b want %b", k, tx_a, exp_level(8'hA5, k, 4)); end
      if (if_a.done !== (k == 40))
        begin errors++; $display("[TB] FAIL single_done k=%0d: got %b want %b", k, if_a.done, k == 40); end
      if (if_a.ready !== 1'b1)
        begin errors++; $display("[TB] FAIL single_ready k=%0d: got %b want 1", k, if_a.ready); end
      if (if_a.busy !== (k <= 40))
        begin errors++; $display("[TB] FAIL single_busy k=%0d: got %b want %b", k, if_a.busy, k <= 40); end
    end
  endtask

  task automatic test_back_to_back();
    logic want;
    send_a(8'h00);
    for (int k = 1; k <= 81; k++) begin
      if (k == 6) begin
        if_a.rts  = 1'b1;
        if_a.data = 8'hFF;
      end
      step();
      if_a.rts = 1'b0;
      want = (k <= 40) ? exp_level(8'h00, k, 4) : (k <= 80) ? exp_level(8'hFF, k - 40, 4) : 1'b1;
      checks += 2;
      if (tx_a !== want)
        begin errors++; $display("[TB] FAIL b2b_tx k=%0d: got %b want %b", k, tx_a, want); end
      if (if_a.done !== (k == 40 || k == 80))
        begin errors++; $display("[TB] FAIL b2b_done k=%0d: got %b want %b", k, if_a.done, k == 40 || k == 80); end
      if (k == 6) begin
        checks++;
        if (if_a.ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_ready_held: got %b want 0", if_a.ready); end
      end
    end
  endtask

  task automatic test_overrun();
    logic want;
    if_a.rts  = 1'b1;
    if_a.data = 8'h11;
    step();
    checks += 2;
    if (if_a.ready !== 1'b0) begin errors++; $display("[TB] FAIL overrun_ready_k0: got %b want 0", if_a.ready); end
    if (tx_a !== 1'b1)       begin errors++; $display("[TB] FAIL overrun_tx_k0: got %b want 1", tx_a); end
    if_a.data = 8'h22;
    step();
    if_a.data = 8'h33;
    checks += 2;
    if (if_a.ready !== 1'b0) begin errors++; $display("[TB] FAIL overrun_ready_third: got %b want 0", if_a.ready); end
    if (tx_a !== 1'b0)       begin errors++; $display("[TB] FAIL overrun_tx_k1: got %b want 0", tx_a); end
    step();
    if_a.rts = 1'b0;
    for (int k = 3; k <= 90; k++) begin
      step();
      want = (k <= 40) ? exp_level(8'h11, k, 4) : (k <= 80) ? exp_level(8'h22, k - 40, 4) : 1'b1;
      checks += 2;
      if (tx_a !== want)
        begin errors++; $display("[TB] FAIL overrun_tx k=%0d: got %b want %b", k, tx_a, want); end
      if (if_a.busy !== (k <= 80))
        begin errors++; $display("[TB] FAIL overrun_busy k=%0d: got %b want %b", k, if_a.busy, k <= 80); end
    end
  endtask

  task automatic test_two_stop_bits();
    if_b.rts  = 1'b1;
    if_b.data = 8'h80;
    step();
    if_b.rts  = 1'b0;
    for (int k = 1; k <= 35; k++) begin
      step();
      checks += 3;
      if (tx_b !== exp_level(8'h80, k, 3))
        begin errors++; $display("[TB] FAIL stop2_tx k=%0d: got %b want %b", k, tx_b, exp_level(8'h80, k, 3)); end
      if (if_b.done !== (k == 33))
        begin errors++; $display("[TB] FAIL stop2_done k=%0d: got %b want %b", k, if_b.done, k == 33); end
      if (if_b.busy !== (k <= 33))
        begin errors++; $display("[TB] FAIL stop2_busy k=%0d: got %b want %b", k, if_b.busy, k <= 33); end
    end
  endtask

  task automatic test_reset_mid_frame();
    send_a(8'h5A);
    for (int k = 1; k <= 18; k++) begin
      step();
      checks++;
      if (tx_a !== exp_level(8'h5A, k, 4))
        begin errors++; $display("[TB] FAIL midrst_tx k=%0d: got %b want %b", k, tx_a, exp_level(8'h5A, k, 4)); end
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks += 4;
    if (tx_a !== 1'b1)       begin errors++; $display("[TB] FAIL midrst_tx_after: got %b want 1", tx_a); end
    if (if_a.ready !== 1'b1) begin errors++; $display("[TB] FAIL midrst_ready_after: got %b want 1", if_a.ready); end
    if (if_a.busy !== 1'b0)  begin errors++; $display("[TB] FAIL midrst_busy_after: got %b want 0", if_a.busy); end
    if (if_a.done !== 1'b0)  begin errors++; $display("[TB] FAIL midrst_done_after: got %b want 0", if_a.done); end
    for (int k = 0; k < 30; k++) begin
      step();
      checks += 2;
      if (if_a.done !== 1'b0) begin errors++; $display("[TB] FAIL midrst_no_done c=%0d: got %b want 0", k, if_a.done); end
      if (tx_a !== 1'b1)      begin errors++; $display("[TB] FAIL midrst_idle_tx c=%0d: got %b want 1", k, tx_a); end
    end
    send_a(8'h3C);
    for (int k = 1; k <= 41; k++) begin
      step();
      checks += 2;
      if (tx_a !== exp_level(8'h3C, k, 4))
        begin errors++; $display("[TB] FAIL midrst_next_tx k=%0d: got %b want %b", k, tx_a, exp_level(8'h3C, k, 4)); end
      if (if_a.done !== (k == 40))
        begin errors++; $display("[TB] FAIL midrst_next_done k=%0d: got %b want %b", k, if_a.done, k == 40); end
    end
  endtask

  task automatic test_idle_line();
    for (int k = 0; k < 1000; k++) begin
      step();
      checks += 3;
      if (tx_a !== 1'b1)      begin errors++; $display("[TB] FAIL idle_tx c=%0d: got %b want 1", k, tx_a); end
      if (if_a.busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_busy c=%0d: got %b want 0", k, if_a.busy); end
      if (if_a.done !== 1'b0) begin errors++; $display("[TB] FAIL idle_done c=%0d: got %b want 0", k, if_a.done); end
    end
  endtask

  initial begin
    if_a.rts  = 1'b0;
    if_a.data = 8'h00;
    if_b.rts  = 1'b0;
    if_b.data = 8'h00;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_overrun();
    test_two_stop_bits();
    test_reset_mid_frame();
    test_idle_line();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
